// File: rtl/register_serial_parallel_left_rx_pkg.sv
// Shared definitions for the left-shift serial link: operation codes used by
// both the serializer and this receiver, receiver FSM state constants, and
// small helpers for sizing the frame counter.
package register_serial_parallel_left_rx_pkg;

  // Operation codes on the OPR bus (LOAD on the serializer side, RECV here)
  localparam logic [1:0] OPR_HOLD  = 2'd0;
  localparam logic [1:0] OPR_LOAD  = 2'd1;
  localparam logic [1:0] OPR_RECV  = 2'd1;
  localparam logic [1:0] OPR_ABORT = 2'd2;
  localparam logic [1:0] OPR_CLEAR = 2'd3;

  // Receiver FSM states: IDLE when no bits of a frame are held, RECV otherwise
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Number of serial bits in one frame, including the optional parity bit
  function automatic int frame_len(input int width, input bit with_parity);
    return with_parity ? width + 1 : width;
  endfunction

  // Bits needed to count 0 .. frame-1
  function automatic int count_width(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Modulo-FRAME bit counter for the serial receiver. Counts accepted bits,
// flags the bit that completes a frame (wrap) and returns to zero on it.
// A clear request drops any partial count.
module rx_bit_counter #(
  parameter int FRAME = 4,
  parameter int CW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  assign wrap = inc && (cnt == LAST);

  // Advance on each accepted bit, wrap to zero on the final bit of a frame
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/register_serial_parallel_left_rx.sv
// Serial-in / parallel-out receive register, MSB first. Assembles WIDTH
// serial bits into a word and offers it to a consumer over valid/ready.
// A completed word arriving while the previous one is still unconsumed is
// dropped and recorded in the sticky overrun flag.
// Optional feature macro: RX_PARITY_CHECK_EN adds a trailing even-parity bit
// to each frame and reports its check result on parity_err.
module register_serial_parallel_left_rx
  import register_serial_parallel_left_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       OPR,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef RX_PARITY_CHECK_EN
  localparam bit WITH_PARITY = 1'b1;
`else
  localparam bit WITH_PARITY = 1'b0;
`endif

  localparam int FRAME = frame_len(WIDTH, WITH_PARITY);
  localparam int CW    = count_width(FRAME);

  logic             rx_bit;
  logic             abort_frame;
  logic             clear_all;
  logic             frame_done;
  logic             load_ok;
  logic [CW-1:0]    bit_cnt;
  logic [0:0]       state;
  logic [WIDTH-1:0] word;

  assign rx_bit      = (OPR == OPR_RECV) && s_valid;
  assign abort_frame = (OPR == OPR_ABORT) || (OPR == OPR_CLEAR);
  assign clear_all   = (OPR == OPR_CLEAR);
  assign load_ok     = !out_valid || out_ready;

  rx_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .inc   (rx_bit),
    .clr   (abort_frame),
    .cnt   (bit_cnt),
    .wrap  (frame_done)
  );

  assign state = (bit_cnt != '0) ? ST_RECV : ST_IDLE;
  assign busy  = (state == ST_RECV);

`ifdef RX_PARITY_CHECK_EN
  logic [WIDTH-1:0] sr;

  // The word sits whole in sr when the parity bit arrives on s_in
  assign word = sr;

  // Shift in data bits only; the closing parity bit is never stored
  always_ff @(posedge clock) begin
    if (reset || abort_frame) begin
      sr <= '0;
    end else if (rx_bit && !frame_done) begin
      sr <= {sr[WIDTH-2:0], s_in};
    end
  end

  // Parity result travels with the word it belongs to, so it follows the same drop rule
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (frame_done && load_ok) begin
      parity_err <= ^{word, s_in};
    end
  end
`else
  logic [WIDTH-2:0] sr;

  // The final bit completes the word straight from s_in, so sr keeps only WIDTH-1 bits
  assign word = {sr, s_in};

  // Shift each accepted bit in from the right, MSB first
  always_ff @(posedge clock) begin
    if (reset || abort_frame) begin
      sr <= '0;
    end else if (rx_bit) begin
      sr <= word[WIDTH-2:0];
    end
  end

  assign parity_err = 1'b0;
`endif

  // Output register and handshake: load on completion if the slot is free, else flag overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear_all) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (load_ok) begin
        data_out  <= word;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
